// File: rtl/camera_power_sequencer.sv
//==============================================================================
// camera_power_sequencer: OV7670 power-up, reset, settle and SCCB configuration
// sequencing with bounded retries. Revision 1.0
//==============================================================================
`default_nettype none

module camera_power_sequencer #(
    parameter logic [23:0] T_PWDN_CYC      = 24'd250000,
    parameter logic [23:0] T_RST_CYC       = 24'd25000,
    parameter logic [23:0] T_SETTLE_CYC    = 24'd250000,
    parameter logic [23:0] CFG_TIMEOUT_CYC = 24'd2500000,
    parameter logic [1:0]  MAX_RETRIES     = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       cam_pwdn,
    output logic       cam_resetn,
    output logic       cfg_start,
    output logic       pipe_reset,
    output logic       seq_ready,
    output logic       seq_fault,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWDN   = 3'd1,
        RST    = 3'd2,
        SETTLE = 3'd3,
        CFG    = 3'd4,
        RUN    = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t      state, next_state;
    logic [23:0] count, next_count;
    logic [1:0]  retry_cnt, next_retry_cnt;
    logic        next_cam_pwdn, next_cam_resetn, next_cfg_start;
    logic        next_pipe_reset, next_seq_ready, next_seq_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 24'd0;
            retry_cnt  <= 2'd0;
            cam_pwdn   <= 1'b1;
            cam_resetn <= 1'b0;
            cfg_start  <= 1'b0;
            pipe_reset <= 1'b1;
            seq_ready  <= 1'b0;
            seq_fault  <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            retry_cnt  <= next_retry_cnt;
            cam_pwdn   <= next_cam_pwdn;
            cam_resetn <= next_cam_resetn;
            cfg_start  <= next_cfg_start;
            pipe_reset <= next_pipe_reset;
            seq_ready  <= next_seq_ready;
            seq_fault  <= next_seq_fault;
        end
    end

    always_comb begin
        next_state     = state;
        next_count     = count;
        next_retry_cnt = retry_cnt;
        case (state)
            IDLE: begin
                if (pll_locked) begin
                    next_state = PWDN;
                    next_count = T_PWDN_CYC - 24'd1;
                end
            end
            PWDN: begin
                if (count == 24'd0) begin
                    next_state = RST;
                    next_count = T_RST_CYC - 24'd1;
                end else begin
                    next_count = count - 24'd1;
                end
            end
            RST: begin
                if (count == 24'd0) begin
                    next_state = SETTLE;
                    next_count = T_SETTLE_CYC - 24'd1;
                end else begin
                    next_count = count - 24'd1;
                end
            end
            SETTLE: begin
                if (count == 24'd0) begin
                    next_state = CFG;
                    next_count = CFG_TIMEOUT_CYC - 24'd1;
                end else begin
                    next_count = count - 24'd1;
                end
            end
            CFG: begin
                // Error wins over a simultaneous done; a timeout only counts without done.
                if (cfg_error || (!cfg_done && count == 24'd0)) begin
                    if (retry_cnt < MAX_RETRIES) begin
                        next_retry_cnt = retry_cnt + 2'd1;
                        next_state     = PWDN;
                        next_count     = T_PWDN_CYC - 24'd1;
                    end else begin
                        next_state = FAULT;
                    end
                end else if (cfg_done) begin
                    next_state     = RUN;
                    next_retry_cnt = 2'd0;
                end else begin
                    next_count = count - 24'd1;
                end
            end
            RUN:     next_state = RUN;
            FAULT:   next_state = FAULT;
            default: next_state = IDLE;
        endcase

        if (!pll_locked && state != IDLE && state != FAULT) begin
            next_state     = IDLE;
            next_retry_cnt = 2'd0;
        end
    end

    // Outputs are decoded from the next state so the registers line up with state.
    always_comb begin
        next_cam_pwdn   = 1'b1;
        next_cam_resetn = 1'b0;
        next_pipe_reset = 1'b1;
        next_seq_ready  = 1'b0;
        next_seq_fault  = 1'b0;
        next_cfg_start  = (next_state == CFG) && (state != CFG);
        case (next_state)
            RST: next_cam_pwdn = 1'b0;
            SETTLE, CFG: begin
                next_cam_pwdn   = 1'b0;
                next_cam_resetn = 1'b1;
            end
            RUN: begin
                next_cam_pwdn   = 1'b0;
                next_cam_resetn = 1'b1;
                next_pipe_reset = 1'b0;
                next_seq_ready  = 1'b1;
            end
            FAULT:   next_seq_fault = 1'b1;
            default: next_cam_pwdn  = 1'b1;
        endcase
    end

    assign state_dbg = state;

endmodule

`default_nettype wire
